clock_set_ctrl: RTL
===================

# clock_set_ctrl

Time-setting controller that sits directly upstream of the hours (0–11) and minutes (0–59) BCD counters. It debounces two raw push-buttons and runs a RUN → SET_HR → SET_MIN state machine. In RUN it passes the 1 Hz tick through as the counters' enables. In a set state it freezes the counters, drives a BCD load value with a write strobe into the selected counter, and provides a blink flag for the display stage.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required before a button change is accepted (10 ms at 100 MHz).
- BLINK_CYCLES, 50_000_000: half-period of o_blink in set states, in clock cycles.
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_tick  in  1  one-cycle 1 Hz enable pulse from the prescaler.
- i_btn_mode  in  1  raw mode button, active-high, asynchronous to i_clk.
- i_btn_up  in  1  raw increment button, active-high, asynchronous to i_clk.
- i_hours  in  8  current hours BCD from the hour counter.
- i_minutes  in  8  current minutes BCD from the minute counter.
- o_ena_hr  out  1  enable to the hour counter.
- o_ena_min  out  1  enable to the minute counter.
- o_wr_hr  out  1  write/load to the hour counter.
- o_wr_min  out  1  write/load to the minute counter.
- o_hr_val  out  8  BCD hours load value.
- o_min_val  out  8  BCD minutes load value.
- o_mode  out  2  state code: 0 = RUN, 1 = SET_HR, 2 = SET_MIN.
- o_blink  out  1  display-visible flag for the digits being set.

## Operation
- **Button path, per button:**
  - 2-flop synchroniser, then debouncer.
  - The debounced level flips only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any mismatch-free cycle clears the count.
  - Each rising edge of the debounced level produces a one-cycle press pulse.
- **State machine:**
  - RUN →(mode press)→ SET_HR →(mode press)→ SET_MIN →(mode press)→ RUN.
  - Code 3 is unreachable and decodes as RUN.
- **Capture on entry:**
  - Entering SET_HR loads r_hr ← i_hours.
  - Entering SET_MIN loads r_min ← i_minutes.
  - A captured value that is not valid BCD in range (hours > 0x11, minutes > 0x59, or a nibble > 9) loads 0x00.
- **Up press in SET_HR:** r_hr increments in BCD: 0x09→0x10, 0x11→0x00.
- **Up press in SET_MIN:** r_min increments in BCD: 0x09→0x10, 0x59→0x00. There is no carry into hours.
- **Up press in RUN:** ignored.
- **Mode and up press in the same cycle:** mode wins; the up press is discarded.
- **Outputs in RUN:**
  - o_ena_hr = o_ena_min = i_tick (combinational pass-through).
  - o_wr_hr = o_wr_min = 0.
- **Outputs in SET_HR:**
  - o_ena_hr = 1 and o_wr_hr = 1 every cycle, so the counter reloads r_hr continuously.
  - o_ena_min = 0, so minutes are frozen.
  - o_wr_min = 0.
- **Outputs in SET_MIN:** mirror of SET_HR, with r_min driving the minute counter and hours frozen.
- **Load values:** o_hr_val = r_hr and o_min_val = r_min at all times.
- **i_tick in set states:** ignored. Seconds-level time is not preserved across a set.
- **Blink:**
  - RUN: o_blink = 1.
  - Each set-state entry: o_blink set to 1 and the blink counter cleared.
  - Thereafter o_blink toggles every BLINK_CYCLES cycles.

## Timing
- **Reset values:**
  - State RUN, o_mode = 0, r_hr = r_min = 0x00.
  - Debounced levels 0, debounce and blink counters 0.
  - o_wr_* = 0, o_blink = 1, o_*_val = 0x00.
  - o_ena_* = i_tick.
- **Button latency:** a clean press is reported as a press pulse 2 + DEBOUNCE_CYCLES cycles after the raw rise.
- **Press at edge N:**
  - State, r_hr/r_min and o_mode update at edge N+1.
  - o_wr_* and o_ena_* follow state combinationally in the same cycle.
- **Entering SET_HR:** the first o_wr_hr cycle already carries the captured value, so no glitch value is written.
- **Returning to RUN:** the counters resume from the last loaded value on the next i_tick.
- **Reset mid-set:** immediate return to RUN, all write strobes low. The counters keep whatever was last loaded.
- **Button held:** exactly one press pulse per debounced rising edge; there is no auto-repeat.

## Test plan
Parameters for the bench: DEBOUNCE_CYCLES = 4, BLINK_CYCLES = 8.
- **Bounce rejection:** toggle i_btn_up high/low every 2 cycles for 20 cycles → no press pulse. Then hold high for 6 cycles → exactly one pulse.
- **Entry and hour wrap:** i_hours = 0x10; mode press → o_mode = 1, o_hr_val = 0x10, o_wr_hr = 1, o_ena_min = 0. Two up presses → 0x11, then 0x00.
- **Minute wrap and exit:** enter SET_MIN with i_minutes = 0x58; two up presses → 0x59, then 0x00. Mode press → o_mode = 0, wr low, o_ena_* tracks i_tick.
- **Invalid capture:** i_hours = 0x1A at SET_HR entry → o_hr_val = 0x00.
- **Simultaneous presses:** mode and up pulses in the same cycle while in SET_HR → state SET_MIN, r_hr unchanged.
- **Reset and blink:** assert i_reset mid-SET_MIN → o_mode = 0, o_wr_min = 0, o_blink = 1 asynchronously. In SET_HR, o_blink toggles every 8 cycles starting high.

Source files
------------

// File: rtl/clock_set_ctrl_if.sv
// Signal bundle between the time-setting controller, its buttons/prescaler and the BCD counters.
// The controller takes the master side.
interface clock_set_ctrl_if;
    logic       i_tick;
    logic       i_btn_mode;
    logic       i_btn_up;
    logic [7:0] i_hours;
    logic [7:0] i_minutes;
    logic       o_ena_hr;
    logic       o_ena_min;
    logic       o_wr_hr;
    logic       o_wr_min;
    logic [7:0] o_hr_val;
    logic [7:0] o_min_val;
    logic [1:0] o_mode;
    logic       o_blink;

    modport master (
        input  i_tick, i_btn_mode, i_btn_up, i_hours, i_minutes,
        output o_ena_hr, o_ena_min, o_wr_hr, o_wr_min, o_hr_val, o_min_val, o_mode, o_blink
    );

    modport slave (
        output i_tick, i_btn_mode, i_btn_up, i_hours, i_minutes,
        input  o_ena_hr, o_ena_min, o_wr_hr, o_wr_min, o_hr_val, o_min_val, o_mode, o_blink
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: debounces mode/up buttons and runs RUN -> SET_HR -> SET_MIN,
// freezing and reloading the hour/minute BCD counters while a field is being set.
module clock_set_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned BLINK_CYCLES    = 50_000_000
) (
    input logic              i_clk,
    input logic              i_reset,
    clock_set_ctrl_if.master bus
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned BlW = $clog2(BLINK_CYCLES + 1);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StSetHr  = 2'd1,
        StSetMin = 2'd2
    } state_e;

    // Bit 0 is the mode button, bit 1 the up button.
    logic [1:0]          btn_raw;
    logic [1:0]          sync1_q, sync2_q;
    logic [1:0]          deb_q, deb_d;
    logic [1:0]          press_q, press_d;
    logic [1:0][DbW-1:0] db_cnt_q, db_cnt_d;

    state_e         state_q, state_d;
    logic [7:0]     hr_q, hr_d;
    logic [7:0]     min_q, min_d;
    logic           blink_q, blink_d;
    logic [BlW-1:0] blink_cnt_q, blink_cnt_d;

    logic           mode_press, up_press;
    logic           blink_step;
    logic [BlW-1:0] blink_cnt_step;
    logic           ena_hr, ena_min, wr_hr, wr_min, blink_out;
    logic [1:0]     mode_code;

    function automatic logic [7:0] capture_hr(input logic [7:0] v);
        if (v[7:4] > 4'd1 || v[3:0] > 4'd9 || v > 8'h11) return 8'h00;
        return v;
    endfunction

    function automatic logic [7:0] capture_min(input logic [7:0] v);
        if (v[7:4] > 4'd5 || v[3:0] > 4'd9) return 8'h00;
        return v;
    endfunction

    function automatic logic [7:0] inc_hr(input logic [7:0] v);
        if (v == 8'h11) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_min(input logic [7:0] v);
        if (v == 8'h59) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign btn_raw = {bus.i_btn_up, bus.i_btn_mode};

    // Level flips only after DEBOUNCE_CYCLES consecutive mismatching cycles.
    always_comb begin
        deb_d    = deb_q;
        press_d  = '0;
        db_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i]   = sync2_q[i];
                    press_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            press_q  <= '0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            press_q  <= press_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign mode_press = press_q[0];
    assign up_press   = press_q[1] & ~press_q[0];

    always_comb begin
        blink_step     = blink_q;
        blink_cnt_step = blink_cnt_q + 1'b1;
        if (blink_cnt_q == BlW'(BLINK_CYCLES - 1)) begin
            blink_step     = ~blink_q;
            blink_cnt_step = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        hr_d        = hr_q;
        min_d       = min_q;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        ena_hr      = bus.i_tick;
        ena_min     = bus.i_tick;
        wr_hr       = 1'b0;
        wr_min      = 1'b0;
        mode_code   = 2'd0;
        blink_out   = 1'b1;
        case (state_q)
            StSetHr: begin
                ena_hr    = 1'b1;
                wr_hr     = 1'b1;
                ena_min   = 1'b0;
                mode_code = 2'd1;
                blink_out = blink_q;
                if (mode_press) begin
                    state_d     = StSetMin;
                    min_d       = capture_min(bus.i_minutes);
                    blink_d     = 1'b1;
                    blink_cnt_d = '0;
                end else begin
                    if (up_press) hr_d = inc_hr(hr_q);
                    blink_d     = blink_step;
                    blink_cnt_d = blink_cnt_step;
                end
            end
            StSetMin: begin
                ena_min   = 1'b1;
                wr_min    = 1'b1;
                ena_hr    = 1'b0;
                mode_code = 2'd2;
                blink_out = blink_q;
                if (mode_press) begin
                    state_d     = StRun;
                    blink_d     = 1'b1;
                    blink_cnt_d = '0;
                end else begin
                    if (up_press) min_d = inc_min(min_q);
                    blink_d     = blink_step;
                    blink_cnt_d = blink_cnt_step;
                end
            end
            default: begin
                // Capture on entry so the first write cycle already carries a clean value.
                if (mode_press) begin
                    state_d     = StSetHr;
                    hr_d        = capture_hr(bus.i_hours);
                    blink_d     = 1'b1;
                    blink_cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= StRun;
            hr_q        <= 8'h00;
            min_q       <= 8'h00;
            blink_q     <= 1'b1;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hr_q        <= hr_d;
            min_q       <= min_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign bus.o_ena_hr  = ena_hr;
    assign bus.o_ena_min = ena_min;
    assign bus.o_wr_hr   = wr_hr;
    assign bus.o_wr_min  = wr_min;
    assign bus.o_hr_val  = hr_q;
    assign bus.o_min_val = min_q;
    assign bus.o_mode    = mode_code;
    assign bus.o_blink   = blink_out;

endmodule
